mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 4:1 mux datapath: up to four requesters

---
 rtl/mux4_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for a 4:1 mux datapath.
// Four requesters share one output lane. A registered one-hot grant and a
// 2-bit select choose which requester's data reaches data_out. A hold timer
// limits how long one owner may keep the lane while others are waiting.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst_n     in   1         asynchronous active-low reset
//   req       in   4         level request per requester (bit i = requester i)
//   data_in   in   4*DATA_W  lane i at [i*DATA_W +: DATA_W]
//   gnt       out  4         registered one-hot grant, zero when idle
//   sel       out  2         registered index of the current/last owner
//   valid     out  1         high while a grant is active
//   data_out  out  DATA_W    lane[sel] while valid, else zero (combinational)
module mux4_rr_arbiter #(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic                  valid,
  output logic [DATA_W-1:0]     data_out
);

  localparam int unsigned HOLD_W    = $clog2(MAX_HOLD) + 1;
  localparam int unsigned HOLD_LASTI = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LASTI);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [3:0]          others_c;
  logic [1:0]          nxt_c;
  logic [1:0]          pick_c;
  logic                timeout_c;
  logic [DATA_W-1:0]   lane [4];

  // First set bit of r, searching p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Split the flat data bus into per-requester lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  // While granting, sel_q names the owner; others excludes it so a handover
  // can never regrant the same requester.
  assign others_c  = req & ~(4'b0001 << sel_q);
  assign nxt_c     = sel_q + 2'd1;
  assign timeout_c = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state and grant selection.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pick_c  = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          pick_c  = rr_pick(req, ptr_q);
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick_c;
          sel_d   = pick_c;
          hold_d  = '0;
        end
      end

      ST_GRANT: begin
        if (!req[sel_q]) begin
          // Release wins over a coincident timeout; both move ptr past the owner.
          ptr_d  = nxt_c;
          hold_d = '0;
          if (others_c != 4'b0000) begin
            pick_c = rr_pick(others_c, nxt_c);
            gnt_d  = 4'b0001 << pick_c;
            sel_d  = pick_c;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (timeout_c) begin
          // Tenure expired: hand over if anyone waits, otherwise restart the timer.
          hold_d = '0;
          if (others_c != 4'b0000) begin
            ptr_d  = nxt_c;
            pick_c = rr_pick(others_c, nxt_c);
            gnt_d  = 4'b0001 << pick_c;
            sel_d  = pick_c;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign valid    = (state_q == ST_GRANT);
  assign data_out = valid ? lane[sel_q] : '0;

  // Structural invariants of the grant registers.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_sel_matches : assert property (@(posedge clk) disable iff (!rst_n)
    valid |-> (gnt_q == (4'b0001 << sel_q)));
  a_valid_gnt   : assert property (@(posedge clk) disable iff (!rst_n)
    valid == (gnt_q != 4'b0000));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: a vector table for round-robin rotation,
// hand-written sequences for reset, timeout and late-arrival corners, and a
// long randomized run compared against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW = 4;
  localparam int unsigned MH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*DW-1:0] data_in;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic            valid;
  logic [DW-1:0]   data_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: owner index (-1 = idle), pointer, cycles owned so far.
  int m_owner;
  int m_ptr;
  int m_ten;
  int m_sel;

  typedef struct {
    logic [3:0]    req;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl [10];

  mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .sel      (sel),
    .valid    (valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_ten   = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    int w;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        w = pick(r, m_ptr);
        m_owner = w; m_sel = w; m_ten = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        if (others != 4'b0000) begin
          w = pick(others, m_ptr);
          m_owner = w; m_sel = w; m_ten = 1;
        end else begin
          m_owner = -1;
        end
      end else if (MH != 0 && m_ten == int'(MH)) begin
        m_ten = 1;
        if (others != 4'b0000) begin
          m_ptr = (m_owner + 1) % 4;
          w = pick(others, m_ptr);
          m_owner = w; m_sel = w;
        end
      end else begin
        m_ten++;
      end
    end
  endtask

  task automatic check_model(input logic [4*DW-1:0] d);
    logic [3:0]    eg;
    logic [DW-1:0] ed;
    eg = 4'b0000;
    ed = '0;
    if (m_owner >= 0) begin
      eg = 4'b0001 << m_owner;
      ed = d[m_owner*DW +: DW];
    end
    chk("rand_gnt",   32'(gnt),      32'(eg));
    chk("rand_sel",   32'(sel),      32'(m_sel));
    chk("rand_valid", 32'(valid),    32'(m_owner >= 0));
    chk("rand_dout",  32'(data_out), 32'(ed));
  endtask

  // Drive inputs, take one clock edge, advance the model, settle 1 time unit.
  task automatic step(input logic [3:0] r, input logic [4*DW-1:0] d);
    req     = r;
    data_in = d;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  // Async reset pulse placed between edges; outputs must clear immediately.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_gnt"},   32'(gnt),      32'h0);
    chk({tag, "_rst_valid"}, 32'(valid),    32'h0);
    chk({tag, "_rst_sel"},   32'(sel),      32'h0);
    chk({tag, "_rst_dout"},  32'(data_out), 32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [4*DW-1:0] d;
    logic [3:0]      rq;

    // Round-robin rotation: each owner drops its request after two cycles.
    tbl[0] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 4'hA};
    tbl[1] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 4'hA};
    tbl[2] = '{4'b1110, 4'b0010, 2'd1, 1'b1, 4'hB};
    tbl[3] = '{4'b1111, 4'b0010, 2'd1, 1'b1, 4'hB};
    tbl[4] = '{4'b1101, 4'b0100, 2'd2, 1'b1, 4'hC};
    tbl[5] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 4'hC};
    tbl[6] = '{4'b1011, 4'b1000, 2'd3, 1'b1, 4'hD};
    tbl[7] = '{4'b1111, 4'b1000, 2'd3, 1'b1, 4'hD};
    tbl[8] = '{4'b0111, 4'b0001, 2'd0, 1'b1, 4'hA};
    tbl[9] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 4'hA};

    rst_n   = 1'b0;
    req     = 4'b0000;
    data_in = '0;
    model_reset();
    #12;
    chk("reset_gnt",   32'(gnt),      32'h0);
    chk("reset_sel",   32'(sel),      32'h0);
    chk("reset_valid", 32'(valid),    32'h0);
    chk("reset_dout",  32'(data_out), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req, 16'hDCBA);
      chk($sformatf("rr%0d_gnt", i),   32'(gnt),      32'(tbl[i].gnt));
      chk($sformatf("rr%0d_sel", i),   32'(sel),      32'(tbl[i].sel));
      chk($sformatf("rr%0d_valid", i), 32'(valid),    32'(tbl[i].valid));
      chk($sformatf("rr%0d_dout", i),  32'(data_out), 32'(tbl[i].dout));
    end

    // Reset mid-grant with all requesting; timeout hands 0 -> 1 at cycle 9.
    async_reset("t1a");
    for (int n = 1; n <= 10; n++) begin
      step(4'b1111, 16'h4321);
      chk($sformatf("t1_c%0d_gnt", n), 32'(gnt), (n <= 8) ? 32'h1 : 32'h2);
    end
    chk("t1_pre_sel", 32'(sel), 32'h1);
    async_reset("t1b");
    step(4'b1111, 16'h4321);
    chk("t1_first_gnt", 32'(gnt), 32'h1);
    chk("t1_first_sel", 32'(sel), 32'h0);

    // Single request on lane 2, data tracking, then drop.
    async_reset("t2");
    for (int n = 0; n < 3; n++) begin
      d = 16'($urandom);
      step(4'b0100, d);
      chk("t2_gnt",   32'(gnt),      32'h4);
      chk("t2_sel",   32'(sel),      32'h2);
      chk("t2_valid", 32'(valid),    32'h1);
      chk("t2_dout",  32'(data_out), 32'(d[11:8]));
    end
    d = 16'($urandom);
    data_in = d;
    #1;
    chk("t2_dout_comb", 32'(data_out), 32'(d[11:8]));
    step(4'b0000, d);
    chk("t2_drop_gnt",   32'(gnt),      32'h0);
    chk("t2_drop_valid", 32'(valid),    32'h0);
    chk("t2_drop_dout",  32'(data_out), 32'h0);
    chk("t2_drop_sel",   32'(sel),      32'h2);

    // Timeout under contention: req3 joins at cycle 2, takes over at cycle 9.
    async_reset("t4");
    for (int n = 0; n < 11; n++) begin
      step((n >= 2) ? 4'b1001 : 4'b0001, 16'h0000);
      chk($sformatf("t4_c%0d_gnt", n + 1), 32'(gnt), (n + 1 <= 8) ? 32'h1 : 32'h8);
    end

    // Timeout with no contention: requester 0 keeps the grant throughout.
    async_reset("t5");
    for (int n = 0; n < 20; n++) begin
      step(4'b0001, 16'h0000);
      chk($sformatf("t5_c%0d_gnt", n + 1), 32'(gnt), 32'h1);
    end

    // Late arrivals do not preempt; release of 1 goes to 2, then to 0.
    async_reset("t6");
    step(4'b0010, 16'h0); chk("t6_a_gnt", 32'(gnt), 32'h2);
    step(4'b0010, 16'h0); chk("t6_b_gnt", 32'(gnt), 32'h2);
    step(4'b0111, 16'h0); chk("t6_c_gnt", 32'(gnt), 32'h2);
    step(4'b0111, 16'h0); chk("t6_d_gnt", 32'(gnt), 32'h2);
    step(4'b0101, 16'h0); chk("t6_e_gnt", 32'(gnt), 32'h4);
    chk("t6_e_sel", 32'(sel), 32'h2);
    step(4'b0001, 16'h0); chk("t6_f_gnt", 32'(gnt), 32'h1);
    chk("t6_f_sel", 32'(sel), 32'h0);
    step(4'b0000, 16'h0); chk("t6_g_valid", 32'(valid), 32'h0);

    // Randomized run with sticky requests so long tenures and timeouts occur.
    async_reset("rnd");
    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      d = 16'($urandom);
      step(rq, d);
      check_model(d);
      if ($urandom_range(0, 299) == 0) async_reset("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
